// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and constants for the BTB update sequencer.
package btb_update_ctrl_pkg;

    localparam int BTB_XLEN   = 32;
    // Instruction PCs are word aligned, so bits [1:0] never distinguish branches.
    localparam int PC_CMP_LSB = 2;

    typedef struct packed {
        logic [BTB_XLEN-1:0] pc;
        logic [BTB_XLEN-1:0] target;
    } btb_upd_t;

endpackage

// File: rtl/btb_update_ctrl_queue.sv
// Coalescing circular queue of {pc, target} updates: storage, pointers, count and PC match.
module btb_update_ctrl_queue import btb_update_ctrl_pkg::*; #(
    parameter int depth = 4,
    parameter int width = BTB_XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_en_i,
    input  logic [width-1:0]           a_pc_i,
    input  logic [width-1:0]           a_tgt_i,
    input  logic                       b_en_i,
    input  logic [width-1:0]           b_pc_i,
    input  logic [width-1:0]           b_tgt_i,
    input  logic                       drain_i,
    output logic [width-1:0]           head_pc_o,
    output logic [width-1:0]           head_tgt_o,
    output logic [$clog2(depth+1)-1:0] count_o
);

    localparam int PW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    typedef struct packed {
        logic [width-1:0] pc;
        logic [width-1:0] target;
    } upd_t;

    upd_t          ent_q [depth];
    upd_t          ent_d [depth];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail_b;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] off [depth];
    logic [depth-1:0] occ, match_a, match_b;
    logic          hit_a, hit_b, a_new, b_new;
    logic [PW-1:0] idx_a, idx_b;

    // An entry is a coalesce candidate when occupied and not leaving through the drain port.
    always_comb begin : match_logic
        match_a = '0;
        match_b = '0;
        occ     = '0;
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        for (int i = 0; i < depth; i++) begin
            off[i]     = PW'(i) - head_q;
            occ[i]     = (CW'(off[i]) < count_q) && !(drain_i && (PW'(i) == head_q));
            match_a[i] = occ[i] && (ent_q[i].pc[width-1:PC_CMP_LSB] == a_pc_i[width-1:PC_CMP_LSB]);
            match_b[i] = occ[i] && (ent_q[i].pc[width-1:PC_CMP_LSB] == b_pc_i[width-1:PC_CMP_LSB]);
            if (match_a[i]) begin
                hit_a = 1'b1;
                idx_a = PW'(i);
            end
            if (match_b[i]) begin
                hit_b = 1'b1;
                idx_b = PW'(i);
            end
        end
    end

    always_comb begin : write_logic
        ent_d  = ent_q;
        a_new  = a_en_i && !hit_a;
        b_new  = b_en_i && !hit_b;
        tail_b = tail_q + PW'(a_new);
        if (a_en_i) begin
            if (hit_a) begin
                ent_d[idx_a].target = a_tgt_i;
            end else begin
                ent_d[tail_q].pc     = a_pc_i;
                ent_d[tail_q].target = a_tgt_i;
            end
        end
        if (b_en_i) begin
            if (hit_b) begin
                ent_d[idx_b].target = b_tgt_i;
            end else begin
                ent_d[tail_b].pc     = b_pc_i;
                ent_d[tail_b].target = b_tgt_i;
            end
        end
        head_d  = head_q + PW'(drain_i);
        tail_d  = tail_b + PW'(b_new);
        count_d = count_q + CW'(a_new) + CW'(b_new) - CW'(drain_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_pc_o  = ent_q[head_q].pc;
    assign head_tgt_o = ent_q[head_q].target;
    assign count_o    = count_q;

endmodule

// File: rtl/btb_update_ctrl.sv
// Arbitrates EX and decode-JAL updates into a coalescing queue and drains one BTB write per cycle.
module btb_update_ctrl import btb_update_ctrl_pkg::*; #(
    parameter int depth = 4,
    parameter int width = BTB_XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_req,
    input  logic [width-1:0]           ex_pc,
    input  logic [width-1:0]           ex_target,
    output logic                       ex_ready,
    input  logic                       jal_req,
    input  logic [width-1:0]           jal_pc,
    input  logic [width-1:0]           jal_target,
    output logic                       jal_ready,
    input  logic                       hold,
    output logic                       btb_load,
    output logic [width-1:0]           btb_w_pc,
    output logic [width-1:0]           btb_target_in,
    output logic [$clog2(depth+1)-1:0] pending
);

    localparam int CW = $clog2(depth + 1);

    logic [CW-1:0]    count, free;
    logic [width-1:0] head_pc, head_tgt;
    logic             ex_acc, jal_acc, same_pc, jal_new, drain;

    // Readiness uses registered occupancy only; a same-cycle drain frees nothing yet.
    assign free      = CW'(depth) - count;
    assign ex_ready  = !rst && (free >= CW'(1));
    assign jal_ready = !rst && ((free >= CW'(2)) || ((free >= CW'(1)) && !ex_req));

    assign ex_acc  = ex_req && ex_ready;
    assign jal_acc = jal_req && jal_ready;
    assign same_pc = (ex_pc[width-1:PC_CMP_LSB] == jal_pc[width-1:PC_CMP_LSB]);
    // A JAL for the same branch as an accepted EX update is absorbed; EX carries the target.
    assign jal_new = jal_acc && !(ex_acc && same_pc);

    assign drain = !rst && !hold && (count != '0);

    btb_update_ctrl_queue #(
        .depth(depth),
        .width(width)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .a_en_i    (ex_acc),
        .a_pc_i    (ex_pc),
        .a_tgt_i   (ex_target),
        .b_en_i    (jal_new),
        .b_pc_i    (jal_pc),
        .b_tgt_i   (jal_target),
        .drain_i   (drain),
        .head_pc_o (head_pc),
        .head_tgt_o(head_tgt),
        .count_o   (count)
    );

    assign btb_load      = drain;
    assign btb_w_pc      = drain ? head_pc : '0;
    assign btb_target_in = drain ? head_tgt : '0;
    assign pending       = rst ? '0 : count;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl; BTB writes are checked against an expected-write queue.
module tb_btb_update_ctrl;
    import btb_update_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_req, jal_req, hold;
    logic [31:0] ex_pc, ex_target, jal_pc, jal_target;
    logic        ex_ready, jal_ready, btb_load;
    logic [31:0] btb_w_pc, btb_target_in;
    logic [2:0]  pending;

    logic [63:0] exp_q[$];
    btb_upd_t    exp_e;
    int          n_checks = 0;
    int          n_pass   = 0;

    btb_update_ctrl #(.depth(4), .width(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_req       (ex_req),
        .ex_pc        (ex_pc),
        .ex_target    (ex_target),
        .ex_ready     (ex_ready),
        .jal_req      (jal_req),
        .jal_pc       (jal_pc),
        .jal_target   (jal_target),
        .jal_ready    (jal_ready),
        .hold         (hold),
        .btb_load     (btb_load),
        .btb_w_pc     (btb_w_pc),
        .btb_target_in(btb_target_in),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [31:0] tgt);
        ex_req    = v;
        ex_pc     = pc;
        ex_target = tgt;
    endtask

    task automatic drive_jal(input logic v, input logic [31:0] pc, input logic [31:0] tgt);
        jal_req    = v;
        jal_pc     = pc;
        jal_target = tgt;
    endtask

    task automatic expect_write(input logic [31:0] pc, input logic [31:0] tgt);
        exp_q.push_back({pc, tgt});
    endtask

    // Every BTB write must match the oldest expected write.
    always @(negedge clk) begin
        if (btb_load) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'b0, btb_load}, 32'h0);
            end else begin
                exp_e = exp_q.pop_front();
                check("write_pc", btb_w_pc, exp_e.pc);
                check("write_target", btb_target_in, exp_e.target);
            end
        end
    end

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        drive_ex(1'b0, 32'h0, 32'h0);
        drive_jal(1'b0, 32'h0, 32'h0);

        // reset state
        next();
        mid();
        check("rst_ex_ready", {31'b0, ex_ready}, 32'h0);
        check("rst_jal_ready", {31'b0, jal_ready}, 32'h0);
        check("rst_load", {31'b0, btb_load}, 32'h0);
        check("rst_pending", {29'b0, pending}, 32'h0);
        next();
        rst = 1'b0;
        mid();
        check("post_rst_ex_ready", {31'b0, ex_ready}, 32'h1);
        check("post_rst_jal_ready", {31'b0, jal_ready}, 32'h1);
        check("post_rst_pending", {29'b0, pending}, 32'h0);
        check("idle_w_pc", btb_w_pc, 32'h0);

        // single update
        next();
        drive_ex(1'b1, 32'h60, 32'h100);
        expect_write(32'h60, 32'h100);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        mid();
        check("single_pending", {29'b0, pending}, 32'h1);
        next();
        mid();
        check("single_drained", {29'b0, pending}, 32'h0);
        check("single_load_off", {31'b0, btb_load}, 32'h0);
        check("single_tgt_zero", btb_target_in, 32'h0);

        // dual enqueue
        next();
        drive_ex(1'b1, 32'h10, 32'h200);
        drive_jal(1'b1, 32'h20, 32'h300);
        expect_write(32'h10, 32'h200);
        expect_write(32'h20, 32'h300);
        mid();
        check("dual_ex_ready", {31'b0, ex_ready}, 32'h1);
        check("dual_jal_ready", {31'b0, jal_ready}, 32'h1);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        drive_jal(1'b0, 32'h0, 32'h0);
        mid();
        check("dual_pending2", {29'b0, pending}, 32'h2);
        next();
        mid();
        check("dual_pending1", {29'b0, pending}, 32'h1);
        next();
        mid();
        check("dual_pending0", {29'b0, pending}, 32'h0);

        // coalesce under hold
        next();
        hold = 1'b1;
        drive_ex(1'b1, 32'h40, 32'h500);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        drive_jal(1'b1, 32'h44, 32'h600);
        next();
        drive_jal(1'b0, 32'h0, 32'h0);
        drive_ex(1'b1, 32'h40, 32'h700);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        mid();
        check("coal_pending", {29'b0, pending}, 32'h2);
        check("coal_hold_load", {31'b0, btb_load}, 32'h0);
        next();
        hold = 1'b0;
        expect_write(32'h40, 32'h700);
        expect_write(32'h44, 32'h600);
        mid();
        next();
        mid();
        next();
        mid();
        check("coal_drained", {29'b0, pending}, 32'h0);

        // fill to full, backpressure
        next();
        hold = 1'b1;
        drive_ex(1'b1, 32'hA0, 32'h1A0);
        drive_jal(1'b1, 32'hB0, 32'h1B0);
        next();
        drive_jal(1'b0, 32'h0, 32'h0);
        drive_ex(1'b1, 32'hC0, 32'h1C0);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        mid();
        check("free1_pending", {29'b0, pending}, 32'h3);
        check("free1_jal_alone", {31'b0, jal_ready}, 32'h1);
        next();
        drive_ex(1'b1, 32'hD0, 32'h1D0);
        drive_jal(1'b1, 32'hE0, 32'h1E0);
        mid();
        check("free1_ex_ready", {31'b0, ex_ready}, 32'h1);
        check("free1_jal_blocked", {31'b0, jal_ready}, 32'h0);
        next();
        drive_jal(1'b0, 32'h0, 32'h0);
        drive_ex(1'b1, 32'hF0, 32'h1F0);
        mid();
        check("full_pending", {29'b0, pending}, 32'h4);
        check("full_ex_ready", {31'b0, ex_ready}, 32'h0);
        check("full_jal_ready", {31'b0, jal_ready}, 32'h0);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        mid();
        check("full_rejected", {29'b0, pending}, 32'h4);
        next();
        hold = 1'b0;
        expect_write(32'hA0, 32'h1A0);
        expect_write(32'hB0, 32'h1B0);
        expect_write(32'hC0, 32'h1C0);
        expect_write(32'hD0, 32'h1D0);
        mid();
        for (int i = 0; i < 4; i++) begin
            next();
            mid();
        end
        check("full_drained", {29'b0, pending}, 32'h0);

        // same-PC collision: EX wins
        next();
        hold = 1'b1;
        drive_ex(1'b1, 32'h80, 32'h900);
        drive_jal(1'b1, 32'h80, 32'hA00);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        drive_jal(1'b0, 32'h0, 32'h0);
        mid();
        check("collide_pending", {29'b0, pending}, 32'h1);
        next();
        hold = 1'b0;
        expect_write(32'h80, 32'h900);
        mid();
        next();
        mid();
        check("collide_drained", {29'b0, pending}, 32'h0);

        // PC bits [1:0] ignored when coalescing
        next();
        hold = 1'b1;
        drive_ex(1'b1, 32'h100, 32'h1);
        next();
        drive_ex(1'b1, 32'h102, 32'h2);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        mid();
        check("lowbit_pending", {29'b0, pending}, 32'h1);
        next();
        hold = 1'b0;
        expect_write(32'h100, 32'h2);
        mid();
        next();
        mid();

        // draining head is not a coalesce target
        next();
        drive_ex(1'b1, 32'h90, 32'h11);
        expect_write(32'h90, 32'h11);
        next();
        drive_ex(1'b1, 32'h90, 32'h22);
        expect_write(32'h90, 32'h22);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        mid();
        check("headx_pending", {29'b0, pending}, 32'h1);
        next();
        mid();
        check("headx_drained", {29'b0, pending}, 32'h0);

        // reset mid-drain
        next();
        hold = 1'b1;
        drive_ex(1'b1, 32'h300, 32'h3);
        drive_jal(1'b1, 32'h310, 32'h31);
        next();
        drive_jal(1'b0, 32'h0, 32'h0);
        drive_ex(1'b1, 32'h320, 32'h32);
        next();
        drive_ex(1'b0, 32'h0, 32'h0);
        hold = 1'b0;
        expect_write(32'h300, 32'h3);
        mid();
        check("pre_rst_pending", {29'b0, pending}, 32'h3);
        next();
        rst = 1'b1;
        mid();
        check("midrst_load", {31'b0, btb_load}, 32'h0);
        check("midrst_pending", {29'b0, pending}, 32'h0);
        check("midrst_ex_ready", {31'b0, ex_ready}, 32'h0);
        check("midrst_jal_ready", {31'b0, jal_ready}, 32'h0);
        next();
        rst = 1'b0;
        mid();
        check("after_rst_pending", {29'b0, pending}, 32'h0);
        check("after_rst_ex_ready", {31'b0, ex_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            next();
            mid();
        end
        check("after_rst_load", {31'b0, btb_load}, 32'h0);
        check("exp_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
